// File: rtl/hamming_serial_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_serial_encoder
//  Description : Serial-in Hamming(7,4) encoder. Collects nibbles one bit per
//                strobe and presents each codeword with a valid/ready
//                handshake. Define HAMMING_EXT_PARITY_EN for SECDED (8,4).
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_serial_encoder #(
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       bit_valid,
    input  logic       frame_start,
    output logic       in_ready,
`ifdef HAMMING_EXT_PARITY_EN
    output logic [7:0] code_out,
`else
    output logic [6:0] code_out,
`endif
    output logic       code_valid,
    input  logic       code_ready,
    output logic [1:0] bit_count
);

`ifdef HAMMING_EXT_PARITY_EN
    localparam int c_CODE_W = 8;
`else
    localparam int c_CODE_W = 7;
`endif

    localparam logic [0:0] c_ST_COLLECT = 1'b0;
    localparam logic [0:0] c_ST_HOLD    = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [3:0]          r_nib;
    logic [3:0]          w_nib_nxt;
    logic [1:0]          r_count;
    logic [1:0]          w_count_nxt;
    logic [c_CODE_W-1:0] r_code;
    logic [c_CODE_W-1:0] w_code_nxt;
    logic [1:0]          w_slot;
    logic [1:0]          w_idx;
    logic [6:0]          w_code7;

    // Bit i of the result is Hamming position i+1.
    function automatic logic [6:0] f_encode(input logic [3:0] nib);
        logic p1, p2, p4;
        p1 = nib[0] ^ nib[1] ^ nib[3];
        p2 = nib[0] ^ nib[2] ^ nib[3];
        p4 = nib[1] ^ nib[2] ^ nib[3];
        return {nib[3], nib[2], nib[1], p4, nib[0], p2, p1};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_COLLECT;
            r_nib   <= 4'd0;
            r_count <= 2'd0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_nib   <= w_nib_nxt;
            r_count <= w_count_nxt;
            r_code  <= w_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_nib_nxt   = r_nib;
        w_count_nxt = r_count;
        w_code_nxt  = r_code;
        w_slot      = frame_start ? 2'd0 : r_count;
        w_idx       = (MSB_FIRST != 0) ? (2'd3 - w_slot) : w_slot;
        w_code7     = 7'd0;

        case (r_state)
            c_ST_COLLECT: begin
                if (bit_valid) begin
                    // A frame start throws away whatever partial nibble was held.
                    if (frame_start) begin
                        w_nib_nxt = 4'd0;
                    end
                    w_nib_nxt[w_idx] = serial_in;
                    w_count_nxt      = w_slot + 2'd1;
                    if (w_slot == 2'd3) begin
                        w_code7 = f_encode(w_nib_nxt);
`ifdef HAMMING_EXT_PARITY_EN
                        w_code_nxt = {^w_code7, w_code7};
`else
                        w_code_nxt = w_code7;
`endif
                        w_state_nxt = c_ST_HOLD;
                    end
                end
            end
            default: begin
                if (code_ready) begin
                    w_state_nxt = c_ST_COLLECT;
                    w_count_nxt = 2'd0;
                end
            end
        endcase
    end

    assign in_ready   = (r_state == c_ST_COLLECT);
    assign code_valid = (r_state == c_ST_HOLD);
    assign code_out   = r_code;
    assign bit_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_hamming_serial_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamming_serial_encoder
//  Description : Directed self-checking bench for hamming_serial_encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_serial_encoder;

`ifdef HAMMING_EXT_PARITY_EN
    localparam int c_CW = 8;
    localparam logic [7:0] c_CODE_B = 8'h55;
    localparam logic [7:0] c_CODE_F = 8'hFF;
    localparam logic [7:0] c_CODE_0 = 8'h00;
    localparam logic [7:0] c_CODE_1 = 8'h87;
    localparam logic [7:0] c_CODE_6 = 8'h33;
`else
    localparam int c_CW = 7;
    localparam logic [6:0] c_CODE_B = 7'h55;
    localparam logic [6:0] c_CODE_F = 7'h7F;
    localparam logic [6:0] c_CODE_0 = 7'h00;
    localparam logic [6:0] c_CODE_1 = 7'h07;
    localparam logic [6:0] c_CODE_6 = 7'h33;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            serial_in = 1'b0;
    logic            bit_valid = 1'b0;
    logic            frame_start = 1'b0;
    logic            in_ready;
    logic [c_CW-1:0] code_out;
    logic            code_valid;
    logic            code_ready = 1'b1;
    logic [1:0]      bit_count;

    int r_cmp = 0;
    int r_bad = 0;

    hamming_serial_encoder #(.MSB_FIRST(1)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .in_ready    (in_ready),
        .code_out    (code_out),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .bit_count   (bit_count)
    );

    always #5 clk = ~clk;

    // Drive one strobed bit for a single clock; returns 1 time unit after the edge.
    task automatic send_bit(input logic b, input logic fs);
        @(negedge clk);
        serial_in   = b;
        frame_start = fs;
        bit_valid   = 1'b1;
        @(posedge clk);
        #1;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_nibble(input logic [3:0] nib);
        for (int i = 3; i >= 0; i--) send_bit(nib[i], 1'b0);
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        r_cmp++; if (code_valid !== 1'b0) begin r_bad++; $display("FAIL reset_valid got %b exp 0", code_valid); end
        r_cmp++; if (in_ready !== 1'b1) begin r_bad++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        r_cmp++; if (bit_count !== 2'd0) begin r_bad++; $display("FAIL reset_count got %0d exp 0", bit_count); end
        r_cmp++; if (code_out !== '0) begin r_bad++; $display("FAIL reset_code got %h exp 0", code_out); end
    endtask

    task automatic test_basic;
        code_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        r_cmp++; if (bit_count !== 2'd3) begin r_bad++; $display("FAIL basic_count3 got %0d exp 3", bit_count); end
        r_cmp++; if (code_valid !== 1'b0) begin r_bad++; $display("FAIL basic_early_valid got %b exp 0", code_valid); end
        send_bit(1'b1, 1'b0);
        r_cmp++; if (code_valid !== 1'b1) begin r_bad++; $display("FAIL basic_valid got %b exp 1", code_valid); end
        r_cmp++; if (code_out !== c_CODE_B) begin r_bad++; $display("FAIL basic_code got %h exp %h", code_out, c_CODE_B); end
        r_cmp++; if (in_ready !== 1'b0) begin r_bad++; $display("FAIL basic_hold_ready got %b exp 0", in_ready); end
        @(posedge clk);
        #1;
        r_cmp++; if (code_valid !== 1'b0) begin r_bad++; $display("FAIL basic_valid_1cyc got %b exp 0", code_valid); end
        r_cmp++; if (in_ready !== 1'b1) begin r_bad++; $display("FAIL basic_ready_back got %b exp 1", in_ready); end
        r_cmp++; if (bit_count !== 2'd0) begin r_bad++; $display("FAIL basic_count0 got %0d exp 0", bit_count); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]      nibs [3];
        logic [c_CW-1:0] exps [3];
        nibs[0] = 4'hF; exps[0] = c_CODE_F;
        nibs[1] = 4'h0; exps[1] = c_CODE_0;
        nibs[2] = 4'h1; exps[2] = c_CODE_1;
        code_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_nibble(nibs[k]);
            r_cmp++; if (code_valid !== 1'b1) begin r_bad++; $display("FAIL b2b_valid[%0d] got %b exp 1", k, code_valid); end
            r_cmp++; if (code_out !== exps[k]) begin r_bad++; $display("FAIL b2b_code[%0d] got %h exp %h", k, code_out, exps[k]); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure;
        code_ready = 1'b0;
        send_nibble(4'b0110);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            serial_in = 1'b1;
            bit_valid = 1'b1;
            @(posedge clk);
            #1;
            r_cmp++; if (code_valid !== 1'b1) begin r_bad++; $display("FAIL bp_valid[%0d] got %b exp 1", c, code_valid); end
            r_cmp++; if (code_out !== c_CODE_6) begin r_bad++; $display("FAIL bp_code[%0d] got %h exp %h", c, code_out, c_CODE_6); end
            r_cmp++; if (in_ready !== 1'b0) begin r_bad++; $display("FAIL bp_ready[%0d] got %b exp 0", c, in_ready); end
        end
        bit_valid = 1'b0;
        @(negedge clk);
        code_ready = 1'b1;
        @(posedge clk);
        #1;
        r_cmp++; if (code_valid !== 1'b0) begin r_bad++; $display("FAIL bp_release got %b exp 0", code_valid); end
        r_cmp++; if (bit_count !== 2'd0) begin r_bad++; $display("FAIL bp_count got %0d exp 0", bit_count); end
        send_nibble(4'h1);
        r_cmp++; if (code_out !== c_CODE_1) begin r_bad++; $display("FAIL bp_next_code got %h exp %h", code_out, c_CODE_1); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame_start;
        code_ready = 1'b1;
        // A lone frame_start without a bit must change nothing.
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        r_cmp++; if (bit_count !== 2'd0) begin r_bad++; $display("FAIL fs_idle_count got %0d exp 0", bit_count); end
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        r_cmp++; if (bit_count !== 2'd1) begin r_bad++; $display("FAIL fs_count got %0d exp 1", bit_count); end
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        r_cmp++; if (code_valid !== 1'b0) begin r_bad++; $display("FAIL fs_early_valid got %b exp 0", code_valid); end
        send_bit(1'b1, 1'b0);
        r_cmp++; if (code_valid !== 1'b1) begin r_bad++; $display("FAIL fs_valid got %b exp 1", code_valid); end
        r_cmp++; if (code_out !== c_CODE_F) begin r_bad++; $display("FAIL fs_code got %h exp %h", code_out, c_CODE_F); end
        @(posedge clk);
        #1;
        // frame_start on the would-be 4th bit restarts instead of encoding.
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        r_cmp++; if (code_valid !== 1'b0) begin r_bad++; $display("FAIL fs3_valid got %b exp 0", code_valid); end
        r_cmp++; if (bit_count !== 2'd1) begin r_bad++; $display("FAIL fs3_count got %0d exp 1", bit_count); end
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        r_cmp++; if (code_out !== c_CODE_1) begin r_bad++; $display("FAIL fs3_code got %h exp %h", code_out, c_CODE_1); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midway;
        code_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        r_cmp++; if (bit_count !== 2'd0) begin r_bad++; $display("FAIL rst_mid_count got %0d exp 0", bit_count); end
        r_cmp++; if (code_valid !== 1'b0) begin r_bad++; $display("FAIL rst_mid_valid got %b exp 0", code_valid); end
        code_ready = 1'b0;
        send_nibble(4'b1011);
        r_cmp++; if (code_valid !== 1'b1) begin r_bad++; $display("FAIL rst_hold_valid got %b exp 1", code_valid); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        r_cmp++; if (code_valid !== 1'b0) begin r_bad++; $display("FAIL rst_hold_drop got %b exp 0", code_valid); end
        r_cmp++; if (in_ready !== 1'b1) begin r_bad++; $display("FAIL rst_hold_ready got %b exp 1", in_ready); end
        r_cmp++; if (code_out !== '0) begin r_bad++; $display("FAIL rst_hold_code got %h exp 0", code_out); end
        code_ready = 1'b1;
        send_nibble(4'b0110);
        r_cmp++; if (code_valid !== 1'b1) begin r_bad++; $display("FAIL rst_after_valid got %b exp 1", code_valid); end
        r_cmp++; if (code_out !== c_CODE_6) begin r_bad++; $display("FAIL rst_after_code got %h exp %h", code_out, c_CODE_6); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_frame_start();
        test_reset_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", r_cmp, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
